// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display counter and its receive-side checker.
// Glyphs are active-low, bit order a..g with a in the MSB.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

   // Encoder used by the counter side; anything above 9 shows blank.
   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational decode of one active-low 7-segment glyph back to a BCD digit.
// A blank glyph reads as 0 only where allow_blank is set (leading-zero suppression).
module seg7_digit_dec
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   input  logic       allow_blank,
   output logic [3:0] digit,
   output logic       ok
);

   always_comb begin
      digit = 4'd0;
      ok    = 1'b1;
      case (seg)
         SEG_0:     digit = 4'd0;
         SEG_1:     digit = 4'd1;
         SEG_2:     digit = 4'd2;
         SEG_3:     digit = 4'd3;
         SEG_4:     digit = 4'd4;
         SEG_5:     digit = 4'd5;
         SEG_6:     digit = 4'd6;
         SEG_7:     digit = 4'd7;
         SEG_8:     digit = 4'd8;
         SEG_9:     digit = 4'd9;
         SEG_BLANK: ok    = allow_blank;
         default:   ok    = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_seq_checker.sv
// Receive-side checker for the two-digit 7-segment counter bus: decodes each capture,
// validates the glyphs and tracks the +1 counting sequence with a HUNT/TRACK/LOCKED FSM.
module seg7_seq_checker
   import seg7_pkg::*;
#(
   parameter int MAX_VAL  = 99,
   parameter int LOCK_LEN = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample,
   input  logic [13:0] seg_in,
   output logic [6:0]  value,
   output logic        value_vld,
   output logic        glyph_err,
   output logic        seq_err,
   output logic        locked,
   output logic [7:0]  err_cnt
);

   localparam logic [6:0] MAX_V  = 7'(MAX_VAL);
   localparam logic [3:0] LOCK_N = 4'(LOCK_LEN);

   logic [3:0] tens, units;
   logic       tens_ok, units_ok;
   logic [6:0] dec_val, exp_val;
   logic       legal, hit;
   logic [7:0] err_inc;
   logic [3:0] good;
   state_t     state;

   seg7_digit_dec u_tens (
      .seg         (seg_in[13:7]),
      .allow_blank (1'b1),
      .digit       (tens),
      .ok          (tens_ok)
   );

   seg7_digit_dec u_units (
      .seg         (seg_in[6:0]),
      .allow_blank (1'b0),
      .digit       (units),
      .ok          (units_ok)
   );

   assign dec_val = 7'(tens) * 7'd10 + 7'(units);
   assign legal   = tens_ok & units_ok & (dec_val <= MAX_V);
   assign exp_val = (value == MAX_V) ? 7'd0 : value + 7'd1;
   assign hit     = (dec_val == exp_val);
   assign err_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
   assign locked  = (state == LOCKED);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value     <= '0;
         value_vld <= 1'b0;
         glyph_err <= 1'b0;
         seq_err   <= 1'b0;
         err_cnt   <= '0;
         good      <= '0;
         state     <= HUNT;
      end else begin
         glyph_err <= 1'b0;
         seq_err   <= 1'b0;
         if (sample) begin
            if (!legal) begin
               // value keeps the last good capture so software can see where it broke
               glyph_err <= 1'b1;
               value_vld <= 1'b0;
               err_cnt   <= err_inc;
               good      <= '0;
               state     <= HUNT;
            end else begin
               value     <= dec_val;
               value_vld <= 1'b1;
               case (state)
                  HUNT: begin
                     good  <= '0;
                     state <= TRACK;
                  end
                  TRACK: begin
                     if (hit) begin
                        good <= good + 4'd1;
                        if (good + 4'd1 == LOCK_N) state <= LOCKED;
                     end else begin
                        good <= '0;
                     end
                  end
                  LOCKED: begin
                     if (!hit) begin
                        seq_err <= 1'b1;
                        err_cnt <= err_inc;
                        good    <= '0;
                        state   <= TRACK;
                     end
                  end
                  default: state <= HUNT;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_seq_checker.sv
// Scoreboard bench: the driver queues the hand-computed response of each capture and a
// per-cycle monitor checks outputs against it, with pulses dropping back to 0 between captures.
module tb_seg7_seq_checker;

   typedef struct packed {
      logic [6:0] v;
      logic       vv;
      logic       ge;
      logic       se;
      logic       lk;
      logic [7:0] ec;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sample = 1'b0;
   logic [13:0] seg_in = '0;
   logic [6:0]  value;
   logic        value_vld, glyph_err, seq_err, locked;
   logic [7:0]  err_cnt;

   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;
   exp_t q[$];
   exp_t cur = '0;

   logic [6:0] g [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                          7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
   localparam logic [6:0] BLK = 7'h7F;
   localparam logic [6:0] BAD = 7'b1010101;

   seg7_seq_checker #(.MAX_VAL(99), .LOCK_LEN(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .sample    (sample),
      .seg_in    (seg_in),
      .value     (value),
      .value_vld (value_vld),
      .glyph_err (glyph_err),
      .seq_err   (seq_err),
      .locked    (locked),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t act_now();
      return '{value, value_vld, glyph_err, seq_err, locked, err_cnt};
   endfunction

   function automatic exp_t mk(input int v, input bit vv, input bit ge, input bit se,
                               input bit lk, input int ec);
      return '{7'(v), vv, ge, se, lk, 8'(ec)};
   endfunction

   // tens 0 shown blank unless lit0 asks for a lit zero
   function automatic logic [13:0] enc(input int v, input bit lit0 = 1'b0);
      logic [6:0] t;
      t = (v / 10 == 0 && !lit0) ? BLK : g[v / 10];
      return {t, g[v % 10]};
   endfunction

   task automatic check(input string name, input exp_t want);
      exp_t a;
      a = act_now();
      n_tests++;
      if (a !== want) begin
         n_fail++;
         $display("FAIL %s: got v=%0d vld=%0b ge=%0b se=%0b lk=%0b ec=%0d, want v=%0d vld=%0b ge=%0b se=%0b lk=%0b ec=%0d",
                  name, a.v, a.vv, a.ge, a.se, a.lk, a.ec,
                  want.v, want.vv, want.ge, want.se, want.lk, want.ec);
      end
   endtask

   task automatic smp(input logic [13:0] s, input exp_t want);
      @(posedge clk);
      #2;
      seg_in = s;
      sample = 1'b1;
      q.push_back(want);
      @(posedge clk);
      #2;
      sample = 1'b0;
   endtask

   // Every cycle: adopt the queued response after a capture, otherwise expect a hold
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         cur = '0;
      end else if (mon_en) begin
         if (sample) begin
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL scoreboard: capture with empty queue, got v=%0d, want a queued entry", value);
            end else begin
               cur = q.pop_front();
            end
         end else begin
            cur.ge = 1'b0;
            cur.se = 1'b0;
         end
         check(sample ? "capture" : "hold", cur);
      end
   end

   initial begin
      #12;
      check("reset_state", mk(0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #2;
      rst    = 1'b1;
      mon_en = 1'b1;

      // count up from 0 and lock
      smp(14'h3F81, mk(0, 1, 0, 0, 0, 0));
      smp(14'h3FCF, mk(1, 1, 0, 0, 0, 0));
      smp(14'h3F92, mk(2, 1, 0, 0, 1, 0));
      smp(14'h3F86, mk(3, 1, 0, 0, 1, 0));

      // jump to 96 breaks lock, relock at 98, wrap 99 -> 0, lit-zero tens
      smp(enc(96), mk(96, 1, 0, 1, 0, 1));
      smp(enc(97), mk(97, 1, 0, 0, 0, 1));
      smp(enc(98), mk(98, 1, 0, 0, 1, 1));
      smp(enc(99), mk(99, 1, 0, 0, 1, 1));
      smp(enc(0),  mk(0,  1, 0, 0, 1, 1));
      smp(enc(1, 1'b1), mk(1, 1, 0, 0, 1, 1));
      for (int i = 2; i <= 5; i++) smp(enc(i, i[0]), mk(i, 1, 0, 0, 1, 1));

      // skip 6, then relock; then a repeated value
      smp(enc(7),  mk(7,  1, 0, 1, 0, 2));
      smp(enc(8),  mk(8,  1, 0, 0, 0, 2));
      smp(enc(9),  mk(9,  1, 0, 0, 1, 2));
      smp(enc(9),  mk(9,  1, 0, 1, 0, 3));
      smp(enc(10), mk(10, 1, 0, 0, 0, 3));
      smp(enc(11), mk(11, 1, 0, 0, 1, 3));

      // illegal glyphs: blank units, garbage units, garbage tens
      smp({g[1], BLK}, mk(11, 0, 1, 0, 0, 4));
      smp({g[1], BAD}, mk(11, 0, 1, 0, 0, 5));
      smp({BAD, g[0]}, mk(11, 0, 1, 0, 0, 6));

      // HUNT -> TRACK; a break in TRACK costs nothing and re-references
      smp(enc(20), mk(20, 1, 0, 0, 0, 6));
      smp(enc(30), mk(30, 1, 0, 0, 0, 6));
      smp(enc(31), mk(31, 1, 0, 0, 0, 6));
      smp(enc(32), mk(32, 1, 0, 0, 1, 6));
      smp(enc(98), mk(98, 1, 0, 1, 0, 7));
      smp(enc(99), mk(99, 1, 0, 0, 0, 7));
      smp(enc(0),  mk(0,  1, 0, 0, 1, 7));
      smp(enc(99), mk(99, 1, 0, 1, 0, 8));

      // sample low with a busy bus: the monitor expects every output to hold
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #2;
         seg_in = 14'($urandom);
      end
      smp(enc(0), mk(0, 1, 0, 0, 0, 8));

      // async reset between edges
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("async_reset", mk(0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #2;
      rst = 1'b1;
      smp(enc(4), mk(4, 1, 0, 0, 0, 0));

      // counter saturation
      for (int k = 1; k <= 300; k++)
         smp({g[0], BLK}, mk(4, 0, 1, 0, 0, (k > 255) ? 255 : k));

      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d entries left, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
